// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and transaction sequencer for the single-port
// synchronous system RAM. Port 0 is the CPU bus and port 1 is the video/DMA
// fetch. Each grant runs one complete RAM transaction:
// begin strobe, address/write-enable, completion wait, then acknowledge.
// A watchdog ends any transaction that the RAM never completes.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  When defined, simultaneous requests alternate between
//                       the ports. When undefined, port 0 always wins.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_oe,
  output logic              ram_beg,
  input  logic              ram_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                we_q;
  logic                gnt_q;
  logic                last_q;
  logic                err_q, err_nxt;
  logic [7:0]          wdog_q, wdog_nxt;
  logic                take;
  logic                win;
  logic                capture;

  // Next-state, arbitration and watchdog decisions
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    wdog_nxt  = wdog_q;
    take      = 1'b0;
    win       = 1'b0;
    capture   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (m0_req && m1_req) win = ~last_q;
    else                  win = m1_req;
`else
    win = ~m0_req;
`endif
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wdog_nxt  = 8'd0;
        err_nxt   = 1'b0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A completion seen in the last allowed cycle still counts as success
        if (ram_rd) begin
          capture   = ~we_q;
          state_nxt = DONE;
        end else if (wdog_q == TO_CNT) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          wdog_nxt  = wdog_q + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched request and captured read data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      wdog_q  <= 8'd0;
    end else begin
      state  <= state_nxt;
      err_q  <= err_nxt;
      wdog_q <= wdog_nxt;
      if (take) begin
        gnt_q   <= win;
        last_q  <= win;
        addr_q  <= win ? m1_addr  : m0_addr;
        we_q    <= win ? m1_we    : m0_we;
        wdata_q <= win ? m1_wdata : m0_wdata;
      end
      if (capture) rdata_q <= ram_din;
    end
  end

  // RAM-side strobes are decoded from the state; the bus is driven only in ISSUE/WAIT
  always_comb begin
    ram_beg  = (state == ISSUE);
    ram_we   = ((state == ISSUE) || (state == WAIT)) && we_q;
    ram_oe   = ((state == ISSUE) || (state == WAIT)) && !we_q;
    ram_addr = addr_q;
    ram_dout = wdata_q;
    busy     = (state != IDLE);
    gnt      = gnt_q;
    rdata    = rdata_q;
    m0_ack   = (state == DONE) && !gnt_q;
    m1_ack   = (state == DONE) && gnt_q;
    m0_err   = (state == DONE) && !gnt_q && err_q;
    m1_err   = (state == DONE) && gnt_q && err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural RAM
// model. Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          rq  [2];
  logic          rwe [2];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rwd [2];

  wire           m0_req = rq[0];
  wire           m1_req = rq[1];
  wire           m0_we = rwe[0];
  wire           m1_we = rwe[1];
  wire  [AW-1:0] m0_addr = raddr[0];
  wire  [AW-1:0] m1_addr = raddr[1];
  wire  [DW-1:0] m0_wdata = rwd[0];
  wire  [DW-1:0] m1_wdata = rwd[1];

  logic          m0_ack, m0_err, m1_ack, m1_err, gnt, busy;
  logic [DW-1:0] rdata, ram_dout, ram_din;
  logic [AW-1:0] ram_addr;
  logic          ram_we, ram_oe, ram_beg, ram_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .gnt(gnt), .busy(busy),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_beg(ram_beg), .ram_rd(ram_rd)
  );

  // RAM model: done flag drops on the begin strobe and rises after cur_lat cycles
  logic [DW-1:0] mem [0:1023];
  int  cur_lat = 0;
  bit  hang = 1'b0;
  int  lat_cnt = 0;
  assign ram_din = mem[ram_addr[9:0]];

  always @(posedge clk) begin
    if (ram_beg) begin
      if (!hang && cur_lat == 0) begin
        ram_rd <= 1'b1;
        if (ram_we) mem[ram_addr[9:0]] <= ram_dout;
      end else begin
        ram_rd  <= 1'b0;
        lat_cnt <= cur_lat;
      end
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !hang) begin
        ram_rd <= 1'b1;
        if (ram_we) mem[ram_addr[9:0]] <= ram_dout;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    bit          hang;
    bit          drop;
    int          exp_delay;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vt [7];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, cnt, nack, c, w;
    bit got;
    int exp_g [4];
    logic [15:0] mmem [8];
    logic [15:0] mrdata;
    logic        mlast, pend, pwe, acked;
    int          pport, pack_cyc, free_at, paddr, done_port;
    logic [15:0] pwd;
    logic        exp0, exp1;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    ram_rd = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ctrl", 32'({m0_ack, m1_ack, m0_err, m1_err, ram_beg, ram_we, ram_oe, busy, gnt}), 32'd0);
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_dout", 32'(ram_dout), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed single transactions
    vt[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 1'b0, 3, 1'b0, 16'h0000};
    vt[1] = '{1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, 3, 1'b0, 16'hBEEF};
    vt[2] = '{0, 1'b1, 16'h0020, 16'h1234, 2, 1'b0, 1'b0, 5, 1'b0, 16'hBEEF};
    vt[3] = '{1, 1'b0, 16'h0020, 16'h0000, 1, 1'b0, 1'b0, 4, 1'b0, 16'h1234};
    vt[4] = '{0, 1'b0, 16'h0010, 16'h0000, 0, 1'b1, 1'b0, 3 + TO, 1'b1, 16'h1234};
    vt[5] = '{1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, 3, 1'b0, 16'hBEEF};
    vt[6] = '{0, 1'b1, 16'h0030, 16'h5555, 0, 1'b0, 1'b1, 3, 1'b0, 16'hBEEF};

    for (int i = 0; i < 7; i++) begin
      cur_lat = vt[i].lat;
      hang = vt[i].hang;
      p = vt[i].port;
      rq[p] = 1'b1; rwe[p] = vt[i].we; raddr[p] = vt[i].addr; rwd[p] = vt[i].wdata;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 60) begin
        @(negedge clk);
        if (cnt == 1) begin
          chk("issue_beg", 32'(ram_beg), 32'd1);
          chk("issue_weoe", 32'({ram_we, ram_oe}), 32'({vt[i].we, ~vt[i].we}));
          chk("issue_addr", 32'(ram_addr), 32'(vt[i].addr));
        end
        if (cnt == 2) begin
          chk("wait_beg", 32'(ram_beg), 32'd0);
          chk("wait_weoe", 32'({ram_we, ram_oe, busy}), 32'({vt[i].we, ~vt[i].we, 1'b1}));
        end
        if (m0_ack || m1_ack) begin
          got = 1'b1;
          chk("vec_delay", 32'(cnt), 32'(vt[i].exp_delay));
          chk("vec_ackport", 32'({m1_ack, m0_ack}), (p == 1) ? 32'd2 : 32'd1);
          chk("vec_gnt", 32'(gnt), 32'(p));
          chk("vec_err", 32'({m1_err, m0_err}), vt[i].exp_err ? ((p == 1) ? 32'd2 : 32'd1) : 32'd0);
          chk("vec_rdata", 32'(rdata), 32'(vt[i].exp_rdata));
          chk("done_weoe", 32'({ram_we, ram_oe}), 32'd0);
        end else begin
          @(posedge clk);
          #1;
          cnt++;
          if (vt[i].drop && cnt == 1) rq[p] = 1'b0;
        end
      end
      chk("vec_ack_seen", 32'(got), 32'd1);
      @(posedge clk);
      #1 rq[p] = 1'b0;
      @(posedge clk);
      #1;
    end

    // Both ports requesting continuously
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    do_reset();
    cur_lat = 0;
    hang = 1'b0;
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0010;
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 16'h0020;
    nack = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        chk("both_gnt", 32'(gnt), 32'(exp_g[nack]));
        chk("both_port", 32'({m1_ack, m0_ack}), (exp_g[nack] == 1) ? 32'd2 : 32'd1);
        chk("both_cycle", 32'(k), 32'(3 + 4 * nack));
        nack++;
      end
      @(posedge clk);
      #1;
    end
    chk("both_count", 32'(nack), 32'd4);
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting on a RAM that never answers
    hang = 1'b1;
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_busy", 32'({busy, ram_beg}), 32'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rw_noack_a", 32'({m1_ack, m0_ack}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    hang = 1'b0;
    cur_lat = 0;
    @(negedge clk);
    chk("rw_after", 32'({busy, ram_we, ram_oe, m0_ack, m1_ack}), 32'd0);
    chk("rw_rdata_clr", 32'(rdata), 32'd0);
    c = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      @(negedge clk);
      if (m0_ack || m1_ack) got = 1'b1;
    end
    chk("rw_ack_seen", 32'(got), 32'd1);
    chk("rw_latency", 32'(c), 32'd3);
    chk("rw_rdata", 32'(rdata), 32'hBEEF);
    @(posedge clk);
    #1 rq[0] = 1'b0;

    // Randomized traffic against a transaction-level model
    do_reset();
    hang = 1'b0;
    for (int i = 0; i < 8; i++) mmem[i] = 16'h0000;
    mrdata = 16'h0000;
    mlast = 1'b1;
    pend = 1'b0;
    pport = 0; pack_cyc = 0; free_at = 0; paddr = 0; pwe = 1'b0; pwd = '0;
    done_port = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      acked = 1'b0;
      exp0 = pend && (cyc == pack_cyc) && (pport == 0);
      exp1 = pend && (cyc == pack_cyc) && (pport == 1);
      chk("rnd_ack", 32'({m1_ack, m0_ack}), 32'({exp1, exp0}));
      chk("rnd_excl", 32'(ram_we & ram_oe), 32'd0);
      if (exp0 || exp1) begin
        chk("rnd_gnt", 32'(gnt), 32'(pport));
        chk("rnd_err", 32'({m1_err, m0_err}), 32'd0);
        if (pwe) mmem[paddr] = pwd;
        else     mrdata = mmem[paddr];
        chk("rnd_rdata", 32'(rdata), 32'(mrdata));
        pend = 1'b0;
        acked = 1'b1;
        done_port = pport;
      end
      if (!pend && cyc >= free_at && (rq[0] || rq[1])) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (rq[0] && rq[1]) ? int'(!mlast) : int'(rq[1]);
`else
        w = rq[0] ? 0 : 1;
`endif
        mlast = (w == 1);
        pend = 1'b1;
        pport = w;
        pwe = rwe[w];
        paddr = int'(raddr[w][2:0]);
        pwd = rwd[w];
        cur_lat = $urandom_range(0, 3);
        pack_cyc = cyc + 3 + cur_lat;
        free_at = cyc + 4 + cur_lat;
      end
      @(posedge clk);
      #1;
      if (acked) rq[done_port] = 1'b0;
      for (int q = 0; q < 2; q++) begin
        if (!rq[q] && $urandom_range(0, 2) == 0) begin
          rq[q] = 1'b1;
          rwe[q] = 1'($urandom_range(0, 1));
          raddr[q] = 16'(16'h0100 + $urandom_range(0, 7));
          rwd[q] = 16'($urandom);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port synchronous system RAM. It shares the RAM between requester 0 (CPU bus) and requester 1 (video/DMA fetch) and runs one complete RAM transaction per grant: beginning strobe, address/write-enable, completion wait, data capture and acknowledge. A watchdog terminates any transaction the RAM never completes.

## Interface
Parameters:
- ADDR_W, 16, RAM word-address width
- DATA_W, 16, RAM data width
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- m0_req / m1_req  in  1  request; held high until matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle pulse, coincident with ack, on timeout
- rdata  out  DATA_W  read data, valid in the ack cycle (registered, held until next capture)
- gnt  out  1  index of port owning the current/last transaction
- busy  out  1  high in ISSUE, WAIT, DONE
- ram_addr  out  ADDR_W  RAM address
- ram_dout  out  DATA_W  RAM write data; top level drives the RAM data bus with it while ram_we=1
- ram_din  in  DATA_W  RAM data bus read value
- ram_we, ram_oe  out  1  RAM write enable, output enable (ram_oe = transaction active & !we)
- ram_beg  out  1  RAM transaction-begin strobe
- ram_rd  in  1  RAM done flag (cleared by ram_beg rising, set by RAM on access)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req, select winner, latch its addr/we/wdata into internal registers, set gnt, go to ISSUE. No req: stay.
- ISSUE (1 cycle): ram_beg=1; drive latched addr, ram_we=we, ram_oe=!we, ram_dout=wdata; clear watchdog; go to WAIT.
- WAIT: hold addr/we/oe/dout; ram_beg=0. If ram_rd=1: on read capture ram_din into rdata; go to DONE. Else increment watchdog; on reaching TIMEOUT set err flag, go to DONE.
- DONE (1 cycle): pulse m{gnt}_ack (and m{gnt}_err if flagged); ram_we=ram_oe=0; go to IDLE.
- Arbitration is decided only in IDLE; a transaction is never preempted.
- Requester dropping req mid-transaction: transaction still completes and ack still pulses.
- Write transactions leave rdata unchanged.
- ram_we/ram_oe are never both 1.

## Timing
- Reset: state=IDLE; all acks, errs, ram_beg, ram_we, ram_oe, busy = 0; ram_addr, ram_dout, rdata = 0; gnt=0; watchdog=0; last-granted = 1.
- Reset mid-transaction: abort immediately, no ack, outputs to reset values the next cycle.
- Latency with RAM answering at the first WAIT cycle: req sampled in IDLE at cycle N, ISSUE N+1, WAIT N+2, ack N+3. Throughput: one transaction per 4 cycles.
- Timeout: ack+err at cycle N+3+TIMEOUT; rdata not updated.
- ram_rd is sampled only in WAIT; a stale ram_rd in ISSUE is ignored.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last; last-granted updates at each grant (reset value 1, so port 0 wins first).
- Undefined: fixed priority, port 0 always wins; port 1 can starve.
- Single request: granted immediately in both modes.

## Test plan
- Reset, then m0 write addr 0x0010 data 0xBEEF -> ram_beg at N+1, ram_we=1 N+1..N+2, m0_ack at N+3, m0_err=0.
- m1 read addr 0x0010 after that write -> m1_ack at N+3, rdata=0xBEEF, gnt=1, ram_oe=1 in ISSUE/WAIT.
- Both req held continuously for 4 transactions -> ROUND_ROBIN_EN: grants 0,1,0,1; without: 0,0,0,0.
- RAM model holds ram_rd=0 -> ack+err at N+3+15, rdata unchanged, next request serviced normally.
- reset asserted in WAIT -> no ack, busy=0 and ram_we=0 next cycle, pending req then granted with 3-cycle latency after reset release.
